// File: rtl/simple_pipe_core.sv
// Three-stage (ID/EX/WB) core for the 8-bit, 4-register simple-pipe ISA.
// Define SIMPLE_PIPE_FWD_EN for full EX/WB bypass; otherwise RAW hazards stall ID.
module simple_pipe_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inst,
    input  logic       inst_valid,
    output logic       inst_ready,
    input  logic       stall,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3,
    output logic       retire_valid,
    output logic [7:0] retire_inst
);

    typedef enum logic [1:0] {
        OpNop  = 2'b00,
        OpAdd  = 2'b01,
        OpSet  = 2'b10,
        OpNand = 2'b11
    } op_e;

    logic [7:0] rf_q [4];

    logic       ex_valid_q;
    op_e        ex_op_q;
    logic [1:0] ex_rd_q;
    logic [7:0] ex_a_q;
    logic [7:0] ex_b_q;
    logic [7:0] ex_inst_q;
    logic [7:0] ex_res;

    logic       wb_valid_q;
    op_e        wb_op_q;
    logic [1:0] wb_rd_q;
    logic [7:0] wb_res_q;
    logic [7:0] wb_inst_q;

    logic       retire_valid_q;
    logic [7:0] retire_inst_q;

    op_e        id_op;
    logic [1:0] id_rs1;
    logic [1:0] id_rs2;
    logic [1:0] id_rd;
    logic [7:0] id_a;
    logic [7:0] id_b;
    logic       hazard;
    logic       accept;
    logic       ex_writes;
    logic       wb_writes;

    assign id_op  = op_e'(inst[7:6]);
    assign id_rs1 = inst[5:4];
    assign id_rs2 = inst[3:2];
    assign id_rd  = inst[1:0];

    assign ex_writes = ex_valid_q && (ex_op_q != OpNop);
    assign wb_writes = wb_valid_q && (wb_op_q != OpNop);

    always_comb begin
        ex_res = 8'h00;
        unique case (ex_op_q)
            OpNop:  ex_res = 8'h00;
            OpAdd:  ex_res = ex_a_q + ex_b_q;
            OpSet:  ex_res = ex_a_q;
            OpNand: ex_res = ~(ex_a_q & ex_b_q);
            default: ex_res = 8'h00;
        endcase
    end

`ifdef SIMPLE_PIPE_FWD_EN
    always_comb begin
        id_a = rf_q[id_rs1];
        id_b = rf_q[id_rs2];
        // Youngest producer wins: EX result is newer than the one being written back.
        if (ex_writes && (ex_rd_q == id_rs1)) begin
            id_a = ex_res;
        end else if (wb_writes && (wb_rd_q == id_rs1)) begin
            id_a = wb_res_q;
        end
        if (ex_writes && (ex_rd_q == id_rs2)) begin
            id_b = ex_res;
        end else if (wb_writes && (wb_rd_q == id_rs2)) begin
            id_b = wb_res_q;
        end
        // SET carries its immediate through the A operand.
        if (id_op == OpSet) begin
            id_a = {4'b0000, inst[5:2]};
        end
    end

    assign hazard = 1'b0;
`else
    logic uses_src;

    always_comb begin
        id_a = rf_q[id_rs1];
        id_b = rf_q[id_rs2];
        if (id_op == OpSet) begin
            id_a = {4'b0000, inst[5:2]};
        end
    end

    assign uses_src = (id_op == OpAdd) || (id_op == OpNand);
    assign hazard   = uses_src &&
                      ((ex_writes && ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2))) ||
                       (wb_writes && ((wb_rd_q == id_rs1) || (wb_rd_q == id_rs2))));
`endif

    assign inst_ready = !stall && !hazard;
    assign accept     = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 8'h00;
            end
            ex_valid_q     <= 1'b0;
            ex_op_q        <= OpNop;
            ex_rd_q        <= 2'b00;
            ex_a_q         <= 8'h00;
            ex_b_q         <= 8'h00;
            ex_inst_q      <= 8'h00;
            wb_valid_q     <= 1'b0;
            wb_op_q        <= OpNop;
            wb_rd_q        <= 2'b00;
            wb_res_q       <= 8'h00;
            wb_inst_q      <= 8'h00;
            retire_valid_q <= 1'b0;
            retire_inst_q  <= 8'h00;
        end else if (stall) begin
            retire_valid_q <= 1'b0;
        end else begin
            ex_valid_q <= accept;
            if (accept) begin
                ex_op_q   <= id_op;
                ex_rd_q   <= id_rd;
                ex_a_q    <= id_a;
                ex_b_q    <= id_b;
                ex_inst_q <= inst;
            end
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                wb_op_q   <= ex_op_q;
                wb_rd_q   <= ex_rd_q;
                wb_res_q  <= ex_res;
                wb_inst_q <= ex_inst_q;
            end
            if (wb_writes) begin
                rf_q[wb_rd_q] <= wb_res_q;
            end
            retire_valid_q <= wb_valid_q;
            if (wb_valid_q) begin
                retire_inst_q <= wb_inst_q;
            end
        end
    end

    assign r0           = rf_q[0];
    assign r1           = rf_q[1];
    assign r2           = rf_q[2];
    assign r3           = rf_q[3];
    assign retire_valid = retire_valid_q;
    assign retire_inst  = retire_inst_q;

endmodule

// File: tb/tb_simple_pipe_core.sv
// Directed, table-driven bench for simple_pipe_core: isolated instruction vectors
// plus hand-written reset, RAW, wrap/NAND, stall and bubble/NOP sequences.
module tb_simple_pipe_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] inst;
    logic       inst_valid;
    logic       inst_ready;
    logic       stall;
    logic [7:0] r0, r1, r2, r3;
    logic       retire_valid;
    logic [7:0] retire_inst;

`ifdef SIMPLE_PIPE_FWD_EN
    localparam int ExpAddWaits = 0;
`else
    localparam int ExpAddWaits = 2;
`endif

    simple_pipe_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .stall        (stall),
        .r0           (r0),
        .r1           (r1),
        .r2           (r2),
        .r3           (r3),
        .retire_valid (retire_valid),
        .retire_inst  (retire_inst)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [7:0]  inst;
        logic [31:0] regs;  // {r0, r1, r2, r3}
    } rec_t;

    rec_t rq[$];

    // Retire pulses last one full cycle, so one negedge sample catches each exactly once.
    always @(negedge clk) begin
        if (retire_valid) rq.push_back({retire_inst, r0, r1, r2, r3});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] i, output int waits);
        @(negedge clk);
        inst       = i;
        inst_valid = 1'b1;
        #1;
        waits = 0;
        while (!inst_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!inst_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: inst %0h never accepted, ready %0b required 1", i,
                     inst_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        inst_valid = 1'b0;
        inst       = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 8'h00;
        stall      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rq.delete();
    endtask

    task automatic wait_rq(input string name, input int n);
        int k = 0;
        while (rq.size() < n && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, rq.size(), n);
    endtask

    rec_t tv[10];
    rec_t e;
    int   w;
    logic [7:0] wrap_inst[7];
    logic [7:0] wrap_r0[7];

    initial begin
        tv[0] = {8'h94, 32'h05_00_00_00};
        tv[1] = {8'h99, 32'h05_06_00_00};
        tv[2] = {8'h46, 32'h05_06_0B_00};
        tv[3] = {8'h42, 32'h05_06_0A_00};
        tv[4] = {8'hE7, 32'h05_06_0A_FD};
        tv[5] = {8'h7D, 32'h05_FA_0A_FD};
        tv[6] = {8'h00, 32'h05_FA_0A_FD};
        tv[7] = {8'h80, 32'h00_FA_0A_FD};
        tv[8] = {8'h5F, 32'h00_FA_0A_F7};
        tv[9] = {8'hEE, 32'h00_FA_FD_F7};
        wrap_inst = '{8'hBC, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'hC3};
        wrap_r0   = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hE0};

        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 8'h00;
        stall      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_regs", {r0, r1, r2, r3}, 32'h0);
        chk("reset_retire_valid", 32'(retire_valid), 32'h0);
        chk("reset_retire_inst", 32'(retire_inst), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(inst_ready), 32'h1);

        // Reset with a SET in flight: no late write.
        rq.delete();
        issue(8'h94, w);
        @(negedge clk);
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midflight_reset_regs", {r0, r1, r2, r3}, 32'h0);
        chk("midflight_reset_retires", rq.size(), 0);

        // Table: each instruction issued alone and drained.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            rq.delete();
            issue(tv[k].inst, w);
            idle();
            wait_rq($sformatf("tv%0d_retire_count", k), 1);
            chk($sformatf("tv%0d_regs", k), {r0, r1, r2, r3}, tv[k].regs);
            if (rq.size() > 0) chk($sformatf("tv%0d_retire_inst", k), 32'(rq[0].inst),
                                   32'(tv[k].inst));
        end

        // SET, SET, dependent ADD back to back.
        do_reset();
        issue(8'h94, w);
        issue(8'h99, w);
        chk("set_no_hazard_waits", w, 0);
        issue(8'h46, w);
        chk("add_raw_waits", w, ExpAddWaits);
        idle();
        @(posedge clk);
        #1;
        chk("add_r2_not_yet", 32'(r2), 32'h0);
        @(posedge clk);
        #1;
        chk("add_retire_valid", 32'(retire_valid), 32'h1);
        chk("add_retire_inst", 32'(retire_inst), 32'h46);
        chk("add_r2", 32'(r2), 32'h0B);

        // Wrap and NAND chain.
        do_reset();
        for (int k = 0; k < 7; k++) issue(wrap_inst[k], w);
        idle();
        wait_rq("wrap_retire_count", 7);
        for (int k = 0; k < 7; k++) begin
            if (k < rq.size()) begin
                e = rq[k];
                chk($sformatf("wrap%0d_inst", k), 32'(e.inst), 32'(wrap_inst[k]));
                chk($sformatf("wrap%0d_r0", k), 32'(e.regs[31:24]), 32'(wrap_r0[k]));
            end
        end
        chk("nand_r3", 32'(r3), 32'h1F);

        // Stall three cycles with two in the pipe and one presented.
        do_reset();
        issue(8'h8D, w);
        issue(8'hA6, w);
        @(negedge clk);
        stall      = 1'b1;
        inst       = 8'hB3;
        inst_valid = 1'b1;
        #1;
        chk("stall_ready_low", 32'(inst_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_retire_valid", k), 32'(retire_valid), 32'h0);
            chk($sformatf("stall%0d_regs", k), {r0, r1, r2, r3}, 32'h0);
        end
        chk("stall_no_retires", rq.size(), 0);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        idle();
        wait_rq("stall_retire_count", 3);
        if (rq.size() >= 3) begin
            chk("stall_ret0", rq[0], {8'h8D, 32'h00_03_00_00});
            chk("stall_ret1", rq[1], {8'hA6, 32'h00_03_09_00});
            chk("stall_ret2", rq[2], {8'hB3, 32'h00_03_09_0C});
        end

        // NOPs retire, bubbles do not.
        rq.delete();
        issue(8'h00, w);
        idle();
        @(negedge clk);
        @(negedge clk);
        issue(8'h00, w);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("nop_retire_count", rq.size(), 2);
        for (int k = 0; k < 2; k++) begin
            if (k < rq.size()) chk($sformatf("nop%0d_rec", k), rq[k], {8'h00, 32'h00_03_09_0C});
        end
        chk("nop_regs_final", {r0, r1, r2, r3}, 32'h00_03_09_0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
